// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, clock deglitch filter, 11-bit deframer
// with start/stop/parity checks and frame timeout, feeding a first-word-fall-through byte FIFO.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 16,
  parameter int CHECK_PARITY   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        PS2Clk,
  input  logic                        PS2Data,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        timeout_err,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} st_t;

  // ---------------- synchronisers ----------------
  logic [SYNC_STAGES-1:0] ck_sync_q, dt_sync_q, sync_vld_q;
  logic                   ck_s, dt_s, sync_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ck_sync_q  <= '1;
      dt_sync_q  <= '1;
      sync_vld_q <= '0;
    end else begin
      ck_sync_q  <= {ck_sync_q[SYNC_STAGES-2:0], PS2Clk};
      dt_sync_q  <= {dt_sync_q[SYNC_STAGES-2:0], PS2Data};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ck_s     = ck_sync_q[SYNC_STAGES-1];
  assign dt_s     = dt_sync_q[SYNC_STAGES-1];
  assign sync_vld = sync_vld_q[SYNC_STAGES-1];

  // ---------------- clock filter and falling-edge detect ----------------
  // armed_q blocks edges until the real pin has been seen high after reset,
  // so a clock line already low at reset release never counts as an edge.
  logic          flt_q, flt_d, fall_q, fall_d, armed_q, armed_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    flt_d   = flt_q;
    fcnt_d  = '0;
    fall_d  = 1'b0;
    armed_d = armed_q | (sync_vld & ck_s);
    if (ck_s != flt_q) begin
      if (fcnt_q == FW'(FILTER_CYCLES - 1)) begin
        flt_d  = ck_s;
        fall_d = flt_q & armed_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_q   <= 1'b1;
      fcnt_q  <= '0;
      fall_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      flt_q   <= flt_d;
      fcnt_q  <= fcnt_d;
      fall_q  <= fall_d;
      armed_q <= armed_d;
    end
  end

  // ---------------- deframer FSM ----------------
  st_t           state_q, state_d;
  logic [10:0]   bits_q, bits_d;
  logic [3:0]    bcnt_q, bcnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          to_hit;
  logic          frame_bad, par_bad, push_req;

  assign to_hit = (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bits_q  <= '0;
      bcnt_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      bits_q  <= bits_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (fall_q) begin
          bits_d    = '0;
          bits_d[0] = dt_s;
          bcnt_d    = 4'd1;
          to_d      = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_q) begin
          bits_d[bcnt_q] = dt_s;
          bcnt_d         = bcnt_q + 4'd1;
          to_d           = '0;
          if (bcnt_q == 4'd10) state_d = CHECK;
        end else if (to_hit) begin
          bcnt_d  = '0;
          to_d    = '0;
          state_d = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      CHECK: begin
        bcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_bad = bits_q[0] | ~bits_q[10];
  assign par_bad   = (CHECK_PARITY != 0) && (^bits_q[9:1] != 1'b1);

  always_comb begin
    busy        = 1'b0;
    frame_err   = 1'b0;
    parity_err  = 1'b0;
    timeout_err = 1'b0;
    push_req    = 1'b0;
    case (state_q)
      SHIFT: begin
        busy        = 1'b1;
        timeout_err = ~fall_q & to_hit;
      end
      CHECK: begin
        busy       = 1'b1;
        frame_err  = frame_bad;
        parity_err = ~frame_bad & par_bad;
        push_req   = ~frame_bad & ~par_bad;
      end
      default: ;
    endcase
  end

  // ---------------- FWFT byte FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop, full, push_ok;

  assign pop      = rx_valid & rx_ready;
  assign full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still takes the byte when the consumer frees a slot this cycle.
  assign push_ok  = push_req & (~full | pop);
  assign overflow = push_req & ~push_ok;
  assign cnt_d    = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bits_q[8:1];
  end

  assign rx_valid   = (cnt_q != '0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised PS/2 frame bench: a queue model predicts FIFO contents and error pulses;
// a second instance with parity checking disabled is checked against its own queue.
module tb_ps2_rx_fifo;
  localparam int SYNC = 2, FILT = 4, TMO = 1000, DEPTH = 16, HALF = 50;

  logic       clk = 1'b0, rst_n = 1'b0, ps2c = 1'b1, ps2d = 1'b1, rdy = 1'b0, rdy2 = 1'b1;
  logic [7:0] rxd, rxd2;
  logic [4:0] cnt, cnt2;
  logic       vld, busy, perr, ferr, terr, ovf;
  logic       vld2, busy2, perr2, ferr2, terr2, ovf2;

  int total = 0, bad = 0;
  int cyc = 0, t_drop = 0, t_vld = 0, t_terr = 0;
  int n_perr = 0, n_ferr = 0, n_terr = 0, n_ovf = 0;
  bit saw_busy = 0, vld_prev = 0;
  logic [7:0] popped_in_check;
  byte unsigned mq[$], exp2[$], got2[$];

  ps2_rx_fifo #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO),
                .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1)) u_dut (
    .clk(clk), .reset(rst_n), .PS2Clk(ps2c), .PS2Data(ps2d),
    .rx_data(rxd), .rx_valid(vld), .rx_ready(rdy), .fifo_count(cnt), .busy(busy),
    .parity_err(perr), .frame_err(ferr), .timeout_err(terr), .overflow(ovf));

  ps2_rx_fifo #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO),
                .FIFO_DEPTH(DEPTH), .CHECK_PARITY(0)) u_dut_np (
    .clk(clk), .reset(rst_n), .PS2Clk(ps2c), .PS2Data(ps2d),
    .rx_data(rxd2), .rx_valid(vld2), .rx_ready(rdy2), .fifo_count(cnt2), .busy(busy2),
    .parity_err(perr2), .frame_err(ferr2), .timeout_err(terr2), .overflow(ovf2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (perr) n_perr++;
    if (ferr) n_ferr++;
    if (ovf)  n_ovf++;
    if (terr) begin n_terr++; t_terr = cyc; end
    if (busy) saw_busy = 1;
    if (vld && !vld_prev) t_vld = cyc;
    vld_prev = vld;
    if (vld2) got2.push_back(rxd2);
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // start, d0..d7, parity, stop -- LSB goes out first
  function automatic logic [10:0] mkfr(input logic [7:0] b, input bit start,
                                       input bit parflip, input bit stop);
    return {stop, (~^b) ^ parflip, b, start};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits, input bit pop_chk);
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      wait_cyc(HALF/2);
      ps2c = 1'b0;
      t_drop = cyc;
      if (pop_chk && i == 10) begin
        // land the one-cycle pop on the cycle the stop bit is being checked
        repeat (SYNC + FILT + 1) @(posedge clk);
        #1 rdy = 1'b1;
        popped_in_check = rxd;
        @(posedge clk);
        #1 rdy = 1'b0;
        wait_cyc(HALF - SYNC - FILT - 3);
      end else begin
        wait_cyc(HALF);
      end
      ps2c = 1'b1;
      wait_cyc(HALF/2);
    end
    ps2d = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 stop=0, 3 start=1
  task automatic do_frame(input logic [7:0] b, input int kind, input bit pop_chk);
    int p0, f0, o0, t0, ep, ef, eo;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovf; t0 = n_terr;
    send_bits(mkfr(b, kind == 3, kind == 1, kind != 2), 11, pop_chk);
    wait_cyc(20);
    ef = (kind >= 2) ? 1 : 0;
    ep = (kind == 1) ? 1 : 0;
    eo = 0;
    if (pop_chk) begin
      chk("pop_in_check_byte", popped_in_check, mq[0]);
      void'(mq.pop_front());
    end
    if (kind == 0) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else eo = 1;
    end
    if (kind <= 1) exp2.push_back(b);
    chk("frame_err_pulses", n_ferr - f0, ef);
    chk("parity_err_pulses", n_perr - p0, ep);
    chk("overflow_pulses", n_ovf - o0, eo);
    chk("timeout_pulses", n_terr - t0, 0);
    chk("fifo_count", cnt, mq.size());
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic pop_one();
    chk("head_valid", vld, 1);
    chk("head_byte", rxd, mq[0]);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    void'(mq.pop_front());
  endtask

  task automatic drain();
    while (mq.size() > 0) pop_one();
    chk("empty_valid", vld, 0);
    chk("empty_count", cnt, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, vld, 0);
    chk({tag, "_data"}, rxd, 0);
    chk({tag, "_count"}, cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_errs"}, {perr, ferr, terr, ovf}, 0);
  endtask

  initial begin
    int lat, t0;
    wait_cyc(3);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(10);

    // basic byte, latency from stop-bit pin edge to rx_valid
    do_frame(8'h1C, 0, 0);
    lat = t_vld - t_drop;
    chk("valid_latency_in_window", (lat >= SYNC + FILT + 1 && lat <= SYNC + FILT + 3) ? 1 : 0, 1);
    chk("first_byte", rxd, 8'h1C);
    drain();

    do_frame(8'h1C, 1, 0);
    do_frame(8'h1C, 2, 0);

    // stall after 5 bits
    t0 = n_terr;
    send_bits(mkfr(8'h3C, 0, 0, 1), 5, 0);
    for (int i = 0; i < TMO + 200 && n_terr == t0; i++) wait_cyc(1);
    chk("timeout_pulse", n_terr - t0, 1);
    lat = t_terr - t_drop;
    chk("timeout_latency_in_window", (lat >= TMO + SYNC && lat <= TMO + SYNC + FILT + 2) ? 1 : 0, 1);
    wait_cyc(2);
    chk("busy_after_timeout", busy, 0);
    chk("count_after_timeout", cnt, 0);
    do_frame(8'hF0, 0, 0);
    drain();

    // fill to overflow, then push on a full FIFO while popping in the same cycle
    for (int i = 0; i <= DEPTH; i++) do_frame(8'(i), 0, 0);
    chk("full_count", cnt, DEPTH);
    do_frame(8'hAA, 0, 1);
    chk("full_count_after_swap", cnt, DEPTH);
    drain();

    // glitches, then reset in the middle of a frame with data in the FIFO
    do_frame(8'h33, 0, 0);
    saw_busy = 0;
    t0 = n_perr + n_ferr + n_terr;
    for (int i = 0; i < 6; i++) begin
      ps2d = 1'($urandom_range(0, 1));
      ps2c = 1'b0;
      wait_cyc(2);
      ps2c = 1'b1;
      wait_cyc(20);
    end
    wait_cyc(10);
    chk("glitch_no_busy", saw_busy, 0);
    chk("glitch_no_errs", n_perr + n_ferr + n_terr - t0, 0);
    chk("glitch_count", cnt, 1);
    send_bits(mkfr(8'h77, 0, 0, 1), 6, 0);
    chk("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    wait_cyc(3);
    chk_idle_outputs("midreset");
    mq.delete();
    rst_n = 1'b1;
    wait_cyc(10);
    do_frame(8'h5A, 0, 0);
    drain();

    // random traffic
    for (int i = 0; i < 10; i++) begin
      int k;
      k = $urandom_range(0, 5);
      do_frame(8'($urandom), (k > 3) ? 0 : k, 0);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) pop_one();
    end
    drain();

    wait_cyc(10);
    chk("noparity_bytes", got2.size(), exp2.size());
    for (int i = 0; i < exp2.size() && i < got2.size(); i++)
      chk("noparity_byte", got2[i], exp2[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
